// File: rtl/aes_display_pkg.sv
// Shared constants, types and helpers for the AES hex display path.
package aes_display_pkg;

   localparam int DEF_NUM_DIGITS  = 4;
   localparam int DEF_REFRESH_DIV = 50000;

   typedef logic [DEF_NUM_DIGITS-1:0] digit_sel_t;

   // A single-page configuration still needs a 1-bit page index port.
   function automatic int page_w(input int data_w, input int num_digits);
      int pages;
      pages = data_w / (4 * num_digits);
      return (pages > 1) ? $clog2(pages) : 1;
   endfunction

endpackage

// File: rtl/aes_hex_scanner_if.sv
// Load/paging strobes and scanned display outputs of the AES hex scanner.
interface aes_hex_scanner_if
   import aes_display_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int NUM_DIGITS = DEF_NUM_DIGITS
);

   localparam int PAGE_W = page_w(DATA_W, NUM_DIGITS);

   logic [DATA_W-1:0]     data_in;
   logic                  data_valid;
   logic                  page_next;
   logic [3:0]            nibble_out;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [PAGE_W-1:0]     page_idx;
   logic                  loaded;

   modport master (
      output data_in, data_valid, page_next,
      input  nibble_out, digit_en, page_idx, loaded
   );

   modport slave (
      input  data_in, data_valid, page_next,
      output nibble_out, digit_en, page_idx, loaded
   );

endinterface

// File: rtl/aes_refresh_tick.sv
// Free-running divider: one-cycle tick while the count sits at REFRESH_DIV-1.
module aes_refresh_tick
   import aes_display_pkg::*;
#(
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign tick = (cnt_reg == CNT_W'(REFRESH_DIV - 1));

   always_comb begin
      cnt_next = cnt_reg + 1'b1;
      if (tick) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/aes_hex_scanner.sv
// Pages a captured 128-bit AES value across a multiplexed bank of hex digits;
// nibble_out feeds the seven-segment converter that sits beside this block.
module aes_hex_scanner
   import aes_display_pkg::*;
#(
   parameter int DATA_W      = 128,
   parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
   parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
   input  logic             clk,
   input  logic             rst_n,
   aes_hex_scanner_if.slave bus
);

   localparam int PAGES   = DATA_W / (4 * NUM_DIGITS);
   localparam int PAGE_W  = page_w(DATA_W, NUM_DIGITS);
   localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int NIBBLES = DATA_W / 4;
   localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   logic                  tick;
   logic [DATA_W-1:0]     shadow_reg;
   logic                  loaded_reg;
   logic [PAGE_W-1:0]     page_reg;
   logic [PAGE_W-1:0]     page_sel_next;
   logic [DIG_W-1:0]      digit_reg;
   logic [DIG_W-1:0]      digit_next;
   logic [3:0]            nibble_reg;
   logic [NUM_DIGITS-1:0] digit_en_reg;
   logic [3:0]            nib_arr [NIBBLES];
   logic [NUM_DIGITS-1:0] digit_dec;
   logic [NIB_W-1:0]      nib_idx;

   aes_refresh_tick #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_refresh_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign nib_arr[gi] = shadow_reg[4*gi +: 4];
      end
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
         assign digit_dec[gi] = (digit_reg == DIG_W'(gi));
      end
   endgenerate

   always_comb begin
      digit_next = digit_reg + 1'b1;
      if (digit_reg == DIG_W'(NUM_DIGITS - 1)) begin
         digit_next = '0;
      end
      page_sel_next = page_reg + 1'b1;
      if (page_reg == PAGE_W'(PAGES - 1)) begin
         page_sel_next = '0;
      end
      // Page 0 is the most significant slice of the value.
      nib_idx = NIB_W'((PAGES - 1 - int'(page_reg)) * NUM_DIGITS + int'(digit_reg));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_reg <= '0;
      end else if (tick) begin
         digit_reg <= digit_next;
      end
   end

   // A load outranks a simultaneous page request and always restarts at page 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_reg <= '0;
         loaded_reg <= 1'b0;
         page_reg   <= '0;
      end else if (bus.data_valid) begin
         shadow_reg <= bus.data_in;
         loaded_reg <= 1'b1;
         page_reg   <= '0;
      end else if (bus.page_next) begin
         page_reg   <= page_sel_next;
      end
   end

   // Digit select and nibble share one register stage so they never disagree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nibble_reg   <= '0;
         digit_en_reg <= '0;
      end else if (loaded_reg) begin
         nibble_reg   <= nib_arr[nib_idx];
         digit_en_reg <= digit_dec;
      end else begin
         nibble_reg   <= '0;
         digit_en_reg <= '0;
      end
   end

   assign bus.nibble_out = nibble_reg;
   assign bus.digit_en   = digit_en_reg;
   assign bus.page_idx   = page_reg;
   assign bus.loaded     = loaded_reg;

endmodule

// File: doc/aes_hex_scanner.md
# aes_hex_scanner

- Time-multiplexed display driver sitting directly upstream of the team's hex-to-seven-segment converter.
- Captures a 128-bit AES value (key, plaintext or ciphertext) and pages through it on a small bank of common-select seven-segment digits.
- On each refresh tick, selects one digit and presents that digit's nibble to the converter.
- Paging is driven by a user pulse; a newly loaded value restarts display at the most-significant page.

## Interface
Parameters:
- DATA_W, 128, width of the displayed value; must be a multiple of 4*NUM_DIGITS
- NUM_DIGITS, 4, physical digits driven; PAGES = DATA_W/(4*NUM_DIGITS)
- REFRESH_DIV, 50000, clock cycles each digit stays selected; must be ≥ 2

Ports:
- clk  in  1  single system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  value to display, sampled only on data_valid
- data_valid  in  1  one-cycle load strobe
- page_next  in  1  one-cycle strobe, advance to next page
- nibble_out  out  4  nibble for the hex converter input
- digit_en  out  NUM_DIGITS  one-hot digit select, active-high; bit NUM_DIGITS-1 is leftmost
- page_idx  out  clog2(PAGES)  current page, 0 = most significant
- loaded  out  1  high once any value has been captured

## Operation
- Shadow register holds the captured value; data_in is ignored except on data_valid.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, digit counter advances, wrapping NUM_DIGITS-1 → 0.
- Nibble mapping for page p and digit d:
  - n = (PAGES-1-p)*NUM_DIGITS + d
  - nibble_out = shadow[4n+3:4n]
  - Page 0, digit NUM_DIGITS-1 therefore shows shadow[DATA_W-1:DATA_W-4].
- Blanking: while loaded=0, digit_en = 0 and nibble_out = 0. Counters keep running.
- data_valid:
  - Captures data_in and sets loaded.
  - Resets page to 0.
  - Does not disturb the refresh or digit counters.
- page_next: page increments, wrapping PAGES-1 → 0. Accepted even when loaded=0.
- data_valid and page_next in the same cycle: data_valid wins, page = 0.
- data_valid during scan: the new value appears on the next registered output update; no glitch beyond that update.
- Reset values: shadow = 0, loaded = 0, page_idx = 0, digit counter = 0, refresh counter = 0, nibble_out = 0, digit_en = 0.
- Reset mid-scan clears all of the above immediately, since reset is asynchronous.

## Timing
- All outputs are registered.
- digit_en and nibble_out always change in the same cycle; they are never mismatched.
- Digit advance latency:
  - Refresh counter reaches REFRESH_DIV-1 at edge k.
  - Digit counter advances at edge k+1.
  - Outputs reflect the new digit at edge k+2.
- data_valid sampled at edge k:
  - loaded, page_idx and shadow update at edge k+1.
  - Outputs reflect the new data at edge k+2.
- page_next at edge k: page_idx updates at edge k+1, outputs at edge k+2.
- Each digit is held for exactly REFRESH_DIV cycles in steady state.
- First digit after reset: digit 0. When loaded first rises, outputs begin on whichever digit the counter currently selects.

## Structure
- Shared package aes_display_pkg:
  - NUM_DIGITS and REFRESH_DIV defaults.
  - Digit-select typedef.
  - Page index width function, clog2(DATA_W/(4*NUM_DIGITS)).
- Natural sub-module: aes_refresh_tick, a parameterised divider producing a one-cycle tick at REFRESH_DIV-1.
- The hex converter is instantiated beside this block, not inside it; nibble_out connects straight to its input.

## Test plan
Unless stated, bench uses REFRESH_DIV=4, NUM_DIGITS=4, DATA_W=128.
- Reset then no load → digit_en = 0 and nibble_out = 0 for 64 cycles; loaded = 0.
- Load data_in = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210:
  - Page 0 shows digit3 = 0, digit2 = 1, digit1 = 2, digit0 = 3.
  - Each digit_en one-hot is held for exactly 4 cycles, cycling 0001 → 0010 → 0100 → 1000.
- Paging:
  - 7 page_next pulses → page_idx = 7, digits show 3, 2, 1, 0 (digit3 = 3).
  - 8th pulse → page_idx wraps to 0.
- Simultaneous events:
  - On page 5, assert data_valid and page_next together with data_in = all-F.
  - Required: page_idx = 0 and every digit shows F.
- Reset mid-scan:
  - Assert rst_n low on page 3, digit 2, refresh count 1.
  - Required: all outputs 0 and loaded = 0 immediately.
  - After release, outputs stay blank until the next data_valid.
- Edge parameters:
  - REFRESH_DIV=2, NUM_DIGITS=8 → PAGES = 4, each digit held 2 cycles.
  - Page 3, digit 0 shows shadow[3:0].
